// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, access-type
// constants and the default memory depth used by the CPU and the bench.
package memory_responder_pkg;

  localparam int DEFAULT_DEPTH = 1024;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/memory_responder_ram.sv
// Word RAM with one CPU read/write port (registered read) and one preload
// write port; the preload port wins when both write the same word on an edge.
module ram_1rw_1w
  import memory_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 10
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          cpu_en_i,
  input  logic          cpu_we_i,
  input  logic          cpu_oor_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic [31:0]   rd_data_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic        cpu_wr;

  assign cpu_wr = cpu_en_i && cpu_we_i && !cpu_oor_i
                  && !(ld_we_i && (ld_addr_i == cpu_addr_i));

  // NOTE: the array deliberately has no reset; contents survive reset and
  // the preload port keeps working while reset is held.
  always_ff @(posedge clock_i) begin
    if (cpu_wr) mem_q[cpu_addr_i] <= cpu_wdata_i;
    if (ld_we_i) mem_q[ld_addr_i] <= ld_data_i;
  end

  // Reads see the array as it was before this edge's writes (no bypass).
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      rd_data_q <= '0;
    end else if (cpu_en_i && !cpu_we_i) begin
      rd_data_q <= cpu_oor_i ? '0 : mem_q[cpu_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/memory_responder.sv
// CPU-facing memory responder: captures a request, optionally waits
// WAIT_STATES cycles, then completes with a one-cycle mem_ready pulse.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] MAR,
  input  logic [31:0] MBR_out,
  input  logic        mem_enable,
  input  logic        mem_op,
  output logic [31:0] MBR_in,
  output logic        mem_ready,
  output logic        addr_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        op_q;
  logic        err_q, err_d;

  logic        capture, fire, in_range, ld_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_op;

  assign capture  = (state_q != ST_WAIT) && mem_enable;
  assign fire     = (capture && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 3'd1));

  // With no wait states the access happens on the capture edge itself.
  assign acc_addr  = capture ? MAR     : addr_q;
  assign acc_op    = capture ? mem_op  : op_q;
  assign acc_wdata = capture ? MBR_out : wdata_q;
  assign in_range  = acc_addr < 32'(DEPTH);
  assign ld_we     = load_en && (load_addr < 32'(DEPTH));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_RESP;
      end
      default: begin
        if (!mem_enable) begin
          state_d = ST_IDLE;
        end else if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 3'(WAIT_STATES);
        end
      end
    endcase
  end

  assign err_d = fire ? !in_range : err_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      op_q    <= MEM_READ;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= MAR;
        op_q    <= mem_op;
        wdata_q <= MBR_out;
      end
    end
  end

  assign mem_ready = (state_q == ST_RESP);
  assign addr_err  = mem_ready && err_q;

  ram_1rw_1w #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clock_i    (clock),
    .reset_ni   (reset),
    .cpu_en_i   (fire && reset),
    .cpu_we_i   (acc_op == MEM_WRITE),
    .cpu_oor_i  (!in_range),
    .cpu_addr_i (acc_addr[AW-1:0]),
    .cpu_wdata_i(acc_wdata),
    .rd_data_o  (MBR_in),
    .ld_we_i    (ld_we),
    .ld_addr_i  (load_addr[AW-1:0]),
    .ld_data_i  (load_data)
  );

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (0, 3 and 2 wait states)
// checked every cycle against a transaction-level model plus literal checks.
module tb_memory_responder;
  import memory_responder_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        op;
    logic        ld;
    logic [31:0] mar;
    logic [31:0] wd;
    logic [31:0] la;
    logic [31:0] ldd;
  } drv_t;

  logic        clock;
  drv_t        drv [3];
  logic [31:0] mbr [3];
  logic        rdy [3];
  logic        err [3];

  int n_checks = 0;
  int n_errors = 0;

  memory_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(drv[0].rst), .MAR(drv[0].mar), .MBR_out(drv[0].wd),
    .mem_enable(drv[0].en), .mem_op(drv[0].op), .MBR_in(mbr[0]),
    .mem_ready(rdy[0]), .addr_err(err[0]), .load_en(drv[0].ld),
    .load_addr(drv[0].la), .load_data(drv[0].ldd));

  memory_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(drv[1].rst), .MAR(drv[1].mar), .MBR_out(drv[1].wd),
    .mem_enable(drv[1].en), .mem_op(drv[1].op), .MBR_in(mbr[1]),
    .mem_ready(rdy[1]), .addr_err(err[1]), .load_en(drv[1].ld),
    .load_addr(drv[1].la), .load_data(drv[1].ldd));

  memory_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(drv[2].rst), .MAR(drv[2].mar), .MBR_out(drv[2].wd),
    .mem_enable(drv[2].en), .mem_op(drv[2].op), .MBR_in(mbr[2]),
    .mem_ready(rdy[2]), .addr_err(err[2]), .load_en(drv[2].ld),
    .load_addr(drv[2].la), .load_data(drv[2].ldd));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: a request accepted on edge e completes on edge
  // e+WS; requests arriving while one is outstanding are ignored.
  logic [31:0] m_ram [3][1024];
  bit          m_on   [3];
  bit          m_pend [3];
  int          m_done [3];
  logic        m_sop  [3];
  logic [31:0] m_sadr [3];
  logic [31:0] m_swd  [3];
  logic        m_rdy  [3];
  logic        m_err  [3];
  logic [31:0] m_mbr  [3];
  int          edge_n = 0;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  task automatic complete(input int k, input logic op, input logic [31:0] a,
                          input logic [31:0] wd);
    m_rdy[k] = 1'b1;
    m_err[k] = (a >= 32'd1024);
    if (op == MEM_READ) m_mbr[k] = m_err[k] ? 32'd0 : m_ram[k][a[9:0]];
    else if (!m_err[k]) m_ram[k][a[9:0]] = wd;
  endtask

  always @(posedge clock) begin
    edge_n++;
    for (int k = 0; k < 3; k++) begin
      m_rdy[k] = 1'b0;
      m_err[k] = 1'b0;
      if (!drv[k].rst) begin
        m_on[k]   = 1'b1;
        m_pend[k] = 1'b0;
        m_mbr[k]  = 32'd0;
      end else if (m_pend[k] && edge_n == m_done[k]) begin
        complete(k, m_sop[k], m_sadr[k], m_swd[k]);
        m_pend[k] = 1'b0;
      end else if (!m_pend[k] && drv[k].en) begin
        if (ws_of(k) == 0) begin
          complete(k, drv[k].op, drv[k].mar, drv[k].wd);
        end else begin
          m_pend[k] = 1'b1;
          m_done[k] = edge_n + ws_of(k);
          m_sop[k]  = drv[k].op;
          m_sadr[k] = drv[k].mar;
          m_swd[k]  = drv[k].wd;
        end
      end
      if (drv[k].ld && drv[k].la < 32'd1024) m_ram[k][drv[k].la[9:0]] = drv[k].ldd;
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (m_on[k]) begin
        check($sformatf("model_ready%0d", k), 32'(rdy[k]), 32'(m_rdy[k]));
        check($sformatf("model_err%0d", k), 32'(err[k]), 32'(m_err[k]));
        check($sformatf("model_mbr%0d", k), mbr[k], m_mbr[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [31:0] d);
    drv[k].ld  = 1'b1;
    drv[k].la  = a;
    drv[k].ldd = d;
    cyc(1);
    drv[k].ld  = 1'b0;
  endtask

  task automatic access(input int k, input logic op, input logic [31:0] a,
                        input logic [31:0] wd);
    drv[k].en  = 1'b1;
    drv[k].op  = op;
    drv[k].mar = a;
    drv[k].wd  = wd;
    cyc(1);
    drv[k].en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) drv[k] = '0;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_ready%0d", k), 32'(rdy[k]), 32'd0);
      check($sformatf("reset_mbr%0d", k), mbr[k], 32'd0);
      drv[k].rst = 1'b1;
    end
    cyc(1);

    // Zero wait states: basic read, one-cycle pulse.
    load(0, 1, 5); load(0, 2, 20); load(0, 0, 32'hAAAA); load(0, 976, 32'h1234);
    access(0, MEM_READ, 1, 0);
    check("s1_ready", 32'(rdy[0]), 32'd1);
    check("s1_mbr", mbr[0], 32'd5);
    check("s1_err", 32'(err[0]), 32'd0);
    cyc(1);
    check("s1_pulse", 32'(rdy[0]), 32'd0);

    // Back-to-back reads with enable held high.
    drv[0].en = 1'b1; drv[0].op = MEM_READ; drv[0].mar = 1;
    cyc(1);
    drv[0].mar = 2;
    check("b2b_ready1", 32'(rdy[0]), 32'd1);
    check("b2b_mbr1", mbr[0], 32'd5);
    cyc(1);
    drv[0].en = 1'b0;
    check("b2b_ready2", 32'(rdy[0]), 32'd1);
    check("b2b_mbr2", mbr[0], 32'd20);
    cyc(1);
    check("b2b_idle", 32'(rdy[0]), 32'd0);

    // Out-of-range read and write.
    access(0, MEM_READ, 1024, 0);
    check("oor_rd_ready", 32'(rdy[0]), 32'd1);
    check("oor_rd_err", 32'(err[0]), 32'd1);
    check("oor_rd_mbr", mbr[0], 32'd0);
    cyc(1);
    check("oor_err_idle", 32'(err[0]), 32'd0);
    access(0, MEM_WRITE, 2000, 7);
    check("oor_wr_err", 32'(err[0]), 32'd1);
    check("oor_wr_mbr", mbr[0], 32'd0);
    cyc(1);
    access(0, MEM_READ, 976, 0);
    check("oor_ram_kept", mbr[0], 32'h1234);

    // Load beats a CPU write to the same word on the same edge.
    drv[0].ld = 1'b1; drv[0].la = 4; drv[0].ldd = 22;
    access(0, MEM_WRITE, 4, 11);
    drv[0].ld = 1'b0;
    access(0, MEM_READ, 4, 0);
    check("load_wins", mbr[0], 32'd22);

    // Read of a word loaded on the same edge returns the old value.
    drv[0].ld = 1'b1; drv[0].la = 1; drv[0].ldd = 77;
    access(0, MEM_READ, 1, 0);
    drv[0].ld = 1'b0;
    check("no_bypass_old", mbr[0], 32'd5);
    access(0, MEM_READ, 1, 0);
    check("no_bypass_new", mbr[0], 32'd77);
    cyc(1);

    // Three wait states: write then read, enable toggled during WAIT.
    load(1, 5, 55);
    access(1, MEM_WRITE, 2, 20);
    for (int i = 0; i < 3; i++) begin
      check("ws3_wr_wait", 32'(rdy[1]), 32'd0);
      cyc(1);
    end
    check("ws3_wr_ready", 32'(rdy[1]), 32'd1);
    check("ws3_wr_mbr", mbr[1], 32'd0);
    cyc(1);
    drv[1].en = 1'b1; drv[1].op = MEM_READ; drv[1].mar = 2;
    cyc(1);
    drv[1].op = MEM_WRITE; drv[1].mar = 5; drv[1].wd = 99;
    cyc(1);
    drv[1].en = 1'b0;
    cyc(1);
    drv[1].en = 1'b1;
    cyc(1);
    drv[1].en = 1'b0;
    check("ws3_rd_ready", 32'(rdy[1]), 32'd1);
    check("ws3_rd_mbr", mbr[1], 32'd20);
    cyc(1);
    check("ws3_rd_pulse", 32'(rdy[1]), 32'd0);
    access(1, MEM_READ, 5, 0);
    cyc(3);
    check("ws3_toggle_ignored", mbr[1], 32'd55);
    cyc(1);

    // Two wait states: reset during WAIT discards a pending write.
    load(2, 3, 33);
    access(2, MEM_READ, 3, 0);
    cyc(2);
    check("ws2_rd_mbr", mbr[2], 32'd33);
    cyc(1);
    access(2, MEM_WRITE, 3, 9);
    drv[2].rst = 1'b0;
    drv[2].ld = 1'b1; drv[2].la = 6; drv[2].ldd = 66;
    cyc(1);
    drv[2].ld = 1'b0;
    drv[2].rst = 1'b1;
    check("rst_ready", 32'(rdy[2]), 32'd0);
    check("rst_mbr", mbr[2], 32'd0);
    check("rst_err", 32'(err[2]), 32'd0);
    cyc(1);
    check("rst_no_ready1", 32'(rdy[2]), 32'd0);
    cyc(1);
    check("rst_no_ready2", 32'(rdy[2]), 32'd0);
    access(2, MEM_READ, 3, 0);
    cyc(2);
    check("rst_write_dropped", mbr[2], 32'd33);
    cyc(1);
    access(2, MEM_READ, 6, 0);
    cyc(2);
    check("load_during_reset", mbr[2], 32'd66);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
